// File: rtl/spi_st7735r_rx_if.sv
// Bus bundle for the ST7735R-style SPI receiver: host-side SPI pins in,
// decoded pixel/command stream out toward the frame buffer writer.
interface spi_st7735r_rx_if #(
   parameter int X_W = 8,
   parameter int Y_W = 8
);
   logic           i_sck;
   logic           i_mosi;
   logic           i_cs_n;
   logic           i_dc;
   logic           o_pix_valid;
   logic [15:0]    o_pix_data;
   logic [X_W-1:0] o_pix_x;
   logic [Y_W-1:0] o_pix_y;
   logic           o_cmd_valid;
   logic [7:0]     o_cmd;
   logic           o_disp_on;

   modport master (
      output i_sck, i_mosi, i_cs_n, i_dc,
      input  o_pix_valid, o_pix_data, o_pix_x, o_pix_y, o_cmd_valid, o_cmd, o_disp_on
   );
   modport slave (
      input  i_sck, i_mosi, i_cs_n, i_dc,
      output o_pix_valid, o_pix_data, o_pix_x, o_pix_y, o_cmd_valid, o_cmd, o_disp_on
   );
endinterface

// File: rtl/spi_st7735r_rx.sv
// ST7735R-compatible SPI mode-0 receiver: oversampled byte assembly, command
// decode (CASET/RASET/RAMWR/SWRESET/DISPON/DISPOFF) and windowed RGB565 writes.
module spi_st7735r_rx #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 128,
   parameter int X_W    = 8,
   parameter int Y_W    = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   spi_st7735r_rx_if.slave   io_bus
);
   typedef enum logic [2:0] {S_IDLE, S_CASET, S_RASET, S_RAMWR, S_IGNORE} state_t;

   localparam logic [X_W-1:0] XE_DEF = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0] YE_DEF = Y_W'(HEIGHT - 1);

   state_t         r_state, w_nxt;
   logic [1:0]     r_sck_s, r_mosi_s, r_cs_s, r_dc_s;
   logic           r_sck_d;
   logic [2:0]     r_bcnt;
   logic [6:0]     r_sh;
   logic [1:0]     r_acnt;
   logic [23:0]    r_arg;
   logic           r_phase;
   logic [7:0]     r_hi;
   logic [X_W-1:0] r_xs, r_xe, r_x, r_pix_x;
   logic [Y_W-1:0] r_ys, r_ye, r_y, r_pix_y;
   logic           r_pix_valid, r_cmd_valid, r_disp_on;
   logic [15:0]    r_pix_data;
   logic [7:0]     r_cmd;

   logic           w_cs_hi, w_rise, w_stb, w_dc, w_cmd_stb, w_dat_stb;
   logic [7:0]     w_byte;
   logic [15:0]    w_start, w_end;

   assign w_cs_hi   = r_cs_s[1];
   assign w_rise    = r_sck_s[1] & ~r_sck_d & ~w_cs_hi;
   assign w_stb     = w_rise & (r_bcnt == 3'd7);
   assign w_byte    = {r_sh, r_mosi_s[1]};
   assign w_dc      = r_dc_s[1];
   assign w_cmd_stb = w_stb & ~w_dc;
   assign w_dat_stb = w_stb & w_dc;
   assign w_start   = r_arg[23:8];
   assign w_end     = {r_arg[7:0], w_byte};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sck_s  <= 2'b00;
         r_mosi_s <= 2'b00;
         r_cs_s   <= 2'b11;
         r_dc_s   <= 2'b00;
         r_sck_d  <= 1'b0;
         r_bcnt   <= 3'd0;
         r_sh     <= 7'd0;
      end else begin
         r_sck_s  <= {r_sck_s[0], io_bus.i_sck};
         r_mosi_s <= {r_mosi_s[0], io_bus.i_mosi};
         r_cs_s   <= {r_cs_s[0], io_bus.i_cs_n};
         r_dc_s   <= {r_dc_s[0], io_bus.i_dc};
         r_sck_d  <= r_sck_s[1];
         if (w_cs_hi) begin
            r_bcnt <= 3'd0;
         end else if (w_rise) begin
            r_sh   <= {r_sh[5:0], r_mosi_s[1]};
            r_bcnt <= r_bcnt + 3'd1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_nxt;
   end

   // A new command byte always re-decodes, whatever was in progress.
   always_comb begin
      w_nxt = r_state;
      if (w_cs_hi) begin
         w_nxt = S_IDLE;
      end else if (w_cmd_stb) begin
         case (w_byte)
            8'h2A:   w_nxt = S_CASET;
            8'h2B:   w_nxt = S_RASET;
            8'h2C:   w_nxt = S_RAMWR;
            8'h01:   w_nxt = S_IDLE;
            default: w_nxt = S_IGNORE;
         endcase
      end else if (w_dat_stb && (r_state == S_CASET || r_state == S_RASET) && r_acnt == 2'd3) begin
         w_nxt = S_IGNORE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acnt <= 2'd0;   r_arg <= 24'd0;   r_phase <= 1'b0;  r_hi <= 8'd0;
         r_xs <= '0;       r_xe <= XE_DEF;   r_ys <= '0;       r_ye <= YE_DEF;
         r_x <= '0;        r_y <= '0;        r_pix_x <= '0;    r_pix_y <= '0;
         r_pix_valid <= 1'b0;  r_pix_data <= 16'd0;
         r_cmd_valid <= 1'b0;  r_cmd <= 8'd0;  r_disp_on <= 1'b0;
      end else begin
         r_pix_valid <= 1'b0;
         r_cmd_valid <= 1'b0;
         if (w_cs_hi) begin
            r_phase <= 1'b0;
            r_acnt  <= 2'd0;
         end else if (w_cmd_stb) begin
            r_cmd       <= w_byte;
            r_cmd_valid <= 1'b1;
            r_acnt      <= 2'd0;
            r_phase     <= 1'b0;
            case (w_byte)
               8'h2C: begin r_x <= r_xs; r_y <= r_ys; end
               8'h29: r_disp_on <= 1'b1;
               8'h28: r_disp_on <= 1'b0;
               8'h01: begin
                  r_xs <= '0; r_xe <= XE_DEF; r_ys <= '0; r_ye <= YE_DEF;
                  r_disp_on <= 1'b0;
               end
               default: ;
            endcase
         end else if (w_dat_stb) begin
            case (r_state)
               S_CASET, S_RASET: begin
                  r_acnt <= r_acnt + 2'd1;
                  r_arg  <= {r_arg[15:0], w_byte};
                  if (r_acnt == 2'd3) begin
                     if (r_state == S_CASET) begin
                        r_xs <= w_start[X_W-1:0];
                        r_xe <= w_end[X_W-1:0];
                     end else begin
                        r_ys <= w_start[Y_W-1:0];
                        r_ye <= w_end[Y_W-1:0];
                     end
                  end
               end
               S_RAMWR: begin
                  if (!r_phase) begin
                     r_hi    <= w_byte;
                     r_phase <= 1'b1;
                  end else begin
                     r_phase     <= 1'b0;
                     r_pix_valid <= 1'b1;
                     r_pix_data  <= {r_hi, w_byte};
                     r_pix_x     <= r_x;
                     r_pix_y     <= r_y;
                     // Reversed windows (xs>xe) still converge: x wraps mod 2^X_W until it hits xe.
                     if (r_x == r_xe) begin
                        r_x <= r_xs;
                        r_y <= (r_y == r_ye) ? r_ys : r_y + 1'b1;
                     end else begin
                        r_x <= r_x + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign io_bus.o_pix_valid = r_pix_valid;
   assign io_bus.o_pix_data  = r_pix_data;
   assign io_bus.o_pix_x     = r_pix_x;
   assign io_bus.o_pix_y     = r_pix_y;
   assign io_bus.o_cmd_valid = r_cmd_valid;
   assign io_bus.o_cmd       = r_cmd;
   assign io_bus.o_disp_on   = r_disp_on;
endmodule

// File: doc/spi_st7735r_rx.md
Name: spi_st7735r_rx

Overview:
- FPGA-side ST7735R-compatible SPI receiver (SPI mode 0, MSB first, 4-wire with DC line).
- Oversamples the host's SCK/MOSI/CS_n/DC in the system clock domain and assembles bytes.
- Decodes the subset CASET/RASET/RAMWR/SWRESET/DISPON/DISPOFF/NOP and emits addressed RGB565 pixel writes toward the frame buffer writer.

Parameters:
- WIDTH, 160, panel columns; default column window is 0..WIDTH-1.
- HEIGHT, 128, panel rows; default row window is 0..HEIGHT-1.
- X_W, 8, column coordinate width.
- Y_W, 8, row coordinate width.

Ports:
- i_clk  in  1  system clock; must be at least 4x SCK frequency.
- i_rst  in  1  synchronous reset, active-high.
- i_sck  in  1  SPI clock (asynchronous).
- i_mosi  in  1  SPI data (asynchronous).
- i_cs_n  in  1  chip select, active-low (asynchronous).
- i_dc  in  1  0 = command byte, 1 = data byte (asynchronous).
- o_pix_valid  out  1  one-cycle pixel write strobe.
- o_pix_data  out  16  RGB565 pixel, first received byte in [15:8].
- o_pix_x  out  X_W  pixel column.
- o_pix_y  out  Y_W  pixel row.
- o_cmd_valid  out  1  one-cycle strobe per received command byte.
- o_cmd  out  8  last command byte.
- o_disp_on  out  1  display-on status.

Behaviour:
- Reset values: o_pix_valid=0, o_pix_data=0, o_pix_x=0, o_pix_y=0, o_cmd_valid=0, o_cmd=0, o_disp_on=0. Column window xs=0, xe=WIDTH-1; row window ys=0, ye=HEIGHT-1. FSM in IDLE. Bit counter 0.
- Input sync: each of i_sck, i_mosi, i_cs_n and i_dc goes through a 2-FF synchronizer.
- SCK rising edge is detected on the synchronized signal (prev=0, cur=1) while synchronized cs_n=0. On that edge, MOSI shifts in MSB first.
- When the 8th bit is taken: byte strobe asserts in the same cycle, with DC as sampled on that edge. Bit counter wraps to 0.
- cs_n high (synchronized):
  - bit counter cleared; any partial byte discarded;
  - pixel byte phase cleared;
  - FSM returns to IDLE;
  - window registers and o_disp_on retained.
- Command byte (DC=0):
  - o_cmd updated and o_cmd_valid pulsed in the cycle after the byte strobe.
  - Any command in progress is aborted and the FSM re-decodes from the new byte.
  - 0x2A goes to CASET; 0x2B goes to RASET.
  - 0x2C goes to RAMWR: current position set to (xs,ys), byte phase cleared.
  - 0x29 sets o_disp_on; 0x28 clears it.
  - 0x01 restores the default windows, clears o_disp_on, and goes to IDLE.
  - 0x00 and all other codes go to IGNORE.
- FSM states: IDLE, CASET, RASET, RAMWR, IGNORE.
  - IDLE: data bytes dropped.
  - IGNORE: data bytes dropped until the next command.
  - CASET/RASET: take 4 data bytes in the order start[15:8], start[7:0], end[15:8], end[7:0]. Only the low X_W/Y_W bits are kept. The window register commits only after the 4th byte. Bytes after the 4th are dropped (state becomes IGNORE). A partial sequence leaves the old window unchanged.
  - RAMWR: byte phase 0 latches the high byte. Phase 1 completes the pixel.
- Pixel output: in the cycle after the phase-1 byte strobe, o_pix_valid=1 with o_pix_data={hi,lo} and o_pix_x/o_pix_y equal to the current position. o_pix_data/x/y hold until the next pixel.
- Position advance after each pixel:
  - x==xe: x goes to xs, and y advances.
  - y==ye at that point: y wraps to ys.
  - Otherwise x increments.
  - Window with xs>xe: x increments modulo 2^X_W until it equals xe (same rule applies to rows).
- Simultaneous events: cs_n deassertion takes priority over an SCK edge in the same cycle. i_rst overrides everything, and reset mid-transfer discards all partial state.

Test Plan:
- Reset, then send 0x29 → o_cmd_valid pulse with o_cmd=0x29, o_disp_on=1. Then send 0x28 → o_disp_on=0.
- CASET 0x0000,0x0002; RASET 0x0001,0x0002; RAMWR with 6 pixels 0xF800 → 6 o_pix_valid pulses at (0,1),(1,1),(2,1),(0,2),(1,2),(2,2), all o_pix_data=0xF800.
- Same window, 7 pixels → the 7th pixel wraps to (0,1).
- RAMWR 0x12, then cs_n high, then cs_n low, then data 0x34,0x56 → no pixel output; the data is dropped in IDLE.
- CASET with only 2 data bytes, then RAMWR and 1 pixel 0x07E0 → old window unchanged, pixel at old xs,ys. Then SWRESET and RAMWR with 1 pixel → pixel at (0,0), o_disp_on=0.
- cs_n released after 5 bits, then a full byte 0x2C → decoded as RAMWR; o_cmd=0x2C, not a corrupted value.
